// File: rtl/instr_fetch16.sv
// Instruction fetch stage for the 16-bit CPU.
// Reads the byte-wide instruction memory two bytes per instruction, assembles
// big-endian 16-bit words, queues them in a small prefetch buffer, and hands
// them to decode over a valid/ready handshake. Supports PC redirect and HALT.
module instr_fetch16 #(
    parameter int ADDR_W   = 8,
    parameter int QDEPTH   = 2,
    parameter int RESET_PC = 0
) (
    input  logic              CK,
    input  logic              RST,
    output logic              MEM_RE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_RDATA,
    output logic              IR_VALID,
    output logic [15:0]       IR,
    output logic [ADDR_W-1:0] IR_PC,
    input  logic              IR_READY,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    input  logic              HALT
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_HI   = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fpc;
    logic [7:0]        hi_byte;

    logic [15:0]       q_word [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              pop;
    logic              do_push;
    logic              space;
    logic              push_room;
    logic [CW-1:0]     count_after_pop;
    logic [CW-1:0]     count_after_push;

    assign IR_VALID = (count != '0);
    assign pop      = IR_VALID & IR_READY;

    // Queue occupancy bookkeeping: room checks account for a pop happening this cycle.
    always_comb begin
        count_after_pop  = count - CW'(pop);
        count_after_push = count_after_pop + CW'(1);
        space            = (count_after_pop < CW'(QDEPTH));
        push_room        = (count_after_push < CW'(QDEPTH));
        do_push          = (state == S_PUSH) && !REDIRECT && !RST;
    end

    // Memory read strobe and address, decoded from the current fetch phase.
    always_comb begin
        MEM_RE   = 1'b0;
        MEM_ADDR = '0;
        if (!RST && !REDIRECT) begin
            case (state)
                S_HI: begin
                    if (space && !HALT) begin
                        MEM_RE   = 1'b1;
                        MEM_ADDR = fpc;
                    end
                end
                S_LO: begin
                    MEM_RE   = 1'b1;
                    MEM_ADDR = fpc + ADDR_W'(1);
                end
                S_PUSH: begin
                    if (push_room && !HALT) begin
                        MEM_RE   = 1'b1;
                        MEM_ADDR = fpc + ADDR_W'(2);
                    end
                end
                default: begin
                    MEM_RE   = 1'b0;
                    MEM_ADDR = '0;
                end
            endcase
        end
    end

    // Fetch sequencer, fetch PC and queue pointers; redirect flushes everything in flight.
    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= S_HI;
            fpc     <= ADDR_W'(RESET_PC);
            hi_byte <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else if (REDIRECT) begin
            state   <= S_HI;
            fpc     <= REDIRECT_PC & ~ADDR_W'(1);
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            case (state)
                S_HI: begin
                    if (space && !HALT) begin
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    hi_byte <= MEM_RDATA;
                    state   <= S_PUSH;
                end
                S_PUSH: begin
                    fpc   <= fpc + ADDR_W'(2);
                    state <= (push_room && !HALT) ? S_LO : S_HI;
                end
                default: begin
                    state <= S_HI;
                end
            endcase
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
                count  <= count_after_push;
            end else begin
                count  <= count_after_pop;
            end
        end
    end

    // Queue storage; contents need no reset because outputs are gated by IR_VALID.
    always_ff @(posedge CK) begin
        if (do_push) begin
            q_word[wr_ptr] <= {hi_byte, MEM_RDATA};
            q_pc[wr_ptr]   <= fpc;
        end
    end

    assign IR    = IR_VALID ? q_word[rd_ptr] : 16'h0000;
    assign IR_PC = IR_VALID ? q_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_instr_fetch16.sv
// Testbench for instr_fetch16: directed scenarios plus randomized traffic,
// with popped words checked against an instruction-stream reference model.
module tb_instr_fetch16;

    logic        ck;
    logic        rst;
    logic        mem_re;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        ir_valid;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halt;

    logic [7:0]  mem [256];
    logic [7:0]  exp_pc;
    int          check_count;
    int          error_count;
    int          pop_count;
    int          halt_run;

    instr_fetch16 #(
        .ADDR_W(8),
        .QDEPTH(2),
        .RESET_PC(0)
    ) dut (
        .CK(ck),
        .RST(rst),
        .MEM_RE(mem_re),
        .MEM_ADDR(mem_addr),
        .MEM_RDATA(mem_rdata),
        .IR_VALID(ir_valid),
        .IR(ir),
        .IR_PC(ir_pc),
        .IR_READY(ir_ready),
        .REDIRECT(redirect),
        .REDIRECT_PC(redirect_pc),
        .HALT(halt)
    );

    // Free-running clock.
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Synchronous instruction memory: data appears the cycle after the read strobe.
    always @(posedge ck) begin
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then check the stream model and invariants.
    task automatic applyStimulus(input logic r, input logic rdy, input logic h,
                                 input logic rd, input logic [7:0] rpc);
        logic [7:0]  next_addr;
        logic [15:0] exp_word;
        @(negedge ck);
        rst         = r;
        ir_ready    = rdy;
        halt        = h;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        halt_run = h ? halt_run + 1 : 0;
        if (r) begin
            checkOutput("rst_re", {31'd0, mem_re}, 32'd0);
            checkOutput("rst_addr", {24'd0, mem_addr}, 32'd0);
            exp_pc = 8'h00;
        end else begin
            if (ir_valid && rdy) begin
                next_addr = exp_pc + 8'd1;
                exp_word  = {mem[exp_pc], mem[next_addr]};
                checkOutput("pop_ir", {16'd0, ir}, {16'd0, exp_word});
                checkOutput("pop_pc", {24'd0, ir_pc}, {24'd0, exp_pc});
                exp_pc = exp_pc + 8'd2;
                pop_count++;
            end
            if (!ir_valid) begin
                checkOutput("idle_ir", {8'd0, ir, ir_pc}, 32'd0);
            end
            if (rd) begin
                checkOutput("redir_re", {31'd0, mem_re}, 32'd0);
                exp_pc = rpc & 8'hFE;
            end
            if (halt_run >= 3) begin
                checkOutput("halt_re", {31'd0, mem_re}, 32'd0);
            end
        end
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        logic got_pop;
        check_count = 0;
        error_count = 0;
        pop_count   = 0;
        halt_run    = 0;
        exp_pc      = 8'h00;
        rst         = 1'b1;
        ir_ready    = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        mem_rdata   = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[0] = 8'h00; mem[1] = 8'hC1; mem[2] = 8'h02;
        mem[3] = 8'hE3; mem[4] = 8'h04; mem[5] = 8'h25;
        mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34;

        // Reset then free-run: one word every two cycles, strobe every cycle.
        doReset(2);
        checkOutput("reset_valid", {31'd0, ir_valid}, 32'd0);
        checkOutput("reset_ir", {16'd0, ir}, 32'd0);
        for (int s = 0; s < 8; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput("run_re", {31'd0, mem_re}, 32'd1);
            checkOutput("run_addr", {24'd0, mem_addr}, s);
            checkOutput("run_valid", {31'd0, ir_valid}, (s == 3 || s == 5 || s == 7) ? 32'd1 : 32'd0);
            if (s == 3) checkOutput("run_w0", {16'd0, ir}, 32'h00C1);
            if (s == 5) checkOutput("run_w1", {16'd0, ir}, 32'h02E3);
            if (s == 7) checkOutput("run_w2", {16'd0, ir}, 32'h0425);
        end

        // Backpressure: queue fills, fetch stalls, then drains in order.
        doReset(1);
        for (int s = 0; s < 20; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        checkOutput("bp_stall_re", {31'd0, mem_re}, 32'd0);
        checkOutput("bp_valid", {31'd0, ir_valid}, 32'd1);
        checkOutput("bp_head", {16'd0, ir}, 32'h00C1);
        pop_count = 0;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        checkOutput("bp_pops", pop_count, 32'd3);

        // Redirect during the low-byte phase.
        doReset(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            if (r == 0) begin
                checkOutput("rd_empty", {31'd0, ir_valid}, 32'd0);
                checkOutput("rd_re", {31'd0, mem_re}, 32'd1);
                checkOutput("rd_addr", {24'd0, mem_addr}, 32'h04);
            end
            if (r == 3) begin
                checkOutput("rd_ir", {16'd0, ir}, 32'h0425);
                checkOutput("rd_pc", {24'd0, ir_pc}, 32'h04);
            end
        end

        // PC wrap-around from 0xFE to 0x00.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFE);
        for (int r = 0; r < 6; r++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            if (r == 1) checkOutput("wrap_lo_addr", {24'd0, mem_addr}, 32'hFF);
            if (r == 3) checkOutput("wrap_w0", {8'd0, ir, ir_pc}, 32'h1234FE);
            if (r == 5) checkOutput("wrap_w1", {8'd0, ir, ir_pc}, 32'h00C100);
        end

        // HALT raised while the low byte is in flight.
        doReset(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput("halt_no_re", {31'd0, mem_re}, 32'd0);
            if (k >= 1) checkOutput("halt_valid", {31'd0, ir_valid}, 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("halt_drained", {31'd0, ir_valid}, 32'd0);

        // Reset while pushing into a nearly full queue.
        doReset(1);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        doReset(2);
        checkOutput("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("mid_rst_re", {31'd0, mem_re}, 32'd1);
        checkOutput("mid_rst_addr", {24'd0, mem_addr}, 32'h00);

        // Randomized traffic.
        begin
            logic h;
            h = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                logic r, rd, rdy;
                if ($urandom_range(9) == 0) h = ~h;
                r   = ($urandom_range(199) == 0);
                rd  = ($urandom_range(24) == 0);
                rdy = ($urandom_range(9) < 7);
                applyStimulus(r, rdy, h, rd, 8'($urandom));
            end
        end

        // Final drain: with fetch free to run, a word must appear in bounded time.
        got_pop = 1'b0;
        pop_count = 0;
        for (int n = 0; n < 12 && !got_pop; n++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            if (pop_count > 0) got_pop = 1'b1;
        end
        checkOutput("drain_pop", {31'd0, got_pop}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
